// File: rtl/seg_pkg.sv
// Shared constants for the 4-digit 7-segment scanner: active-low segment
// codes (g..a), blank patterns and the digit count.
package seg_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  localparam logic [7:0] SEG_OFF  = 8'hFF;
  localparam logic [3:0] AN_OFF   = 4'hF;

endpackage

// File: rtl/seg_scan_if.sv
// Display-side bundle: BCD digits, enable/dp/blink controls in, and the
// multiplexed anode/segment drive plus frame pulse out.
interface seg_scan_if;

  logic [3:0] num0;
  logic [3:0] num1;
  logic [3:0] num2;
  logic [3:0] num3;
  logic [3:0] can_num;
  logic [3:0] dp_mask;
  logic       blink;
  logic [3:0] an;
  logic [7:0] seg;
  logic       frame_tick;

  modport master (
    output num0, num1, num2, num3, can_num, dp_mask, blink,
    input  an, seg, frame_tick
  );

  modport slave (
    input  num0, num1, num2, num3, can_num, dp_mask, blink,
    output an, seg, frame_tick
  );

endinterface

// File: rtl/seg_decode.sv
// BCD digit to active-low 7-segment pattern (g..a); codes above 9 show a dash.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed 4-digit 7-segment driver with per-frame input snapshot,
// anti-ghosting blank window, per-digit decimal point and blink.
module seg_scan
  import seg_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYC    = 200,
  parameter int BLINK_FRAMES = 125,
  parameter int CNT_W        = 17
) (
  input  logic      clk,
  input  logic      rst_n,
  seg_scan_if.slave bus
);

  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [FW-1:0]    frame_cnt;
  logic             phase;
  logic [3:0]       shadow_num [NUM_DIGITS];
  logic [3:0]       shadow_can;
  logic [3:0]       shadow_dp;

  logic             tick;
  logic             snap;
  logic             blank;
  logic [3:0]       cur_num;
  logic [6:0]       cur_seg;
  logic [3:0]       sel;

  assign tick    = (cnt == CNT_W'(SCAN_DIV - 1));
  assign snap    = tick && (idx == 2'd3);
  assign cur_num = shadow_num[idx];
  assign sel     = 4'b0001 << idx;
  assign blank   = (cnt < CNT_W'(BLANK_CYC)) || !shadow_can[idx] || (bus.blink && phase);

  seg_decode u_decode (
    .digit (cur_num),
    .seg   (cur_seg)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
      if (tick)
        idx <= idx + 2'd1;
    end
  end

  // Shadow registers only change on the last-digit wrap so a frame never mixes values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++)
        shadow_num[i] <= '0;
      shadow_can <= 4'b0001;
      shadow_dp  <= '0;
      frame_tick_q_reset();
    end else if (snap) begin
      shadow_num[0] <= bus.num0;
      shadow_num[1] <= bus.num1;
      shadow_num[2] <= bus.num2;
      shadow_num[3] <= bus.num3;
      shadow_can    <= bus.can_num;
      shadow_dp     <= bus.dp_mask;
    end
  end

  function automatic void frame_tick_q_reset();
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      phase     <= 1'b0;
    end else if (!bus.blink) begin
      frame_cnt <= '0;
      phase     <= 1'b0;
    end else if (snap) begin
      if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
        frame_cnt <= '0;
        phase     <= ~phase;
      end else begin
        frame_cnt <= frame_cnt + FW'(1);
      end
    end
  end

  // Outputs are registered from pre-edge state, so they trail the scan by one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.an         <= AN_OFF;
      bus.seg        <= SEG_OFF;
      bus.frame_tick <= 1'b0;
    end else begin
      bus.an         <= blank ? AN_OFF : ~sel;
      bus.seg        <= {~shadow_dp[idx], cur_seg};
      bus.frame_tick <= snap;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan: table of display values checked over a
// whole frame, plus coherence, blink and mid-scan reset sequences.
module tb_seg_scan;

  localparam int SCAN_DIV     = 8;
  localparam int BLANK_CYC    = 2;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME_CYC    = 4 * SCAN_DIV;

  logic clk;
  logic rst_n;
  seg_scan_if bus ();

  seg_scan #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYC    (BLANK_CYC),
    .BLINK_FRAMES (BLINK_FRAMES),
    .CNT_W        (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] n0, n1, n2, n3;
    logic [3:0] can;
    logic [3:0] dp;
    logic [7:0] s0, s1, s2, s3;
  } vec_t;

  vec_t vecs [5];
  int total = 0;
  int bad = 0;

  logic [7:0] exp_seg [4];
  logic [3:0] exp_can;
  logic       exp_dark;

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    bus.num0    = v.n0;
    bus.num1    = v.n1;
    bus.num2    = v.n2;
    bus.num3    = v.n3;
    bus.can_num = v.can;
    bus.dp_mask = v.dp;
  endtask

  task automatic set_expect(input vec_t v);
    exp_seg[0] = v.s0;
    exp_seg[1] = v.s1;
    exp_seg[2] = v.s2;
    exp_seg[3] = v.s3;
    exp_can    = v.can;
  endtask

  task automatic set_reset_expect();
    for (int i = 0; i < 4; i++) exp_seg[i] = 8'hC0;
    exp_can = 4'b0001;
  endtask

  // Advance one clock and check the outputs for scan position k of the frame.
  task automatic step_check(input int k);
    int d;
    int c;
    logic [3:0] onehot;
    logic [3:0] exp_an;
    @(negedge clk);
    d = k / SCAN_DIV;
    c = k % SCAN_DIV;
    onehot = 4'b0001 << d;
    exp_an = (c < BLANK_CYC || !exp_can[d] || exp_dark) ? 4'hF : ~onehot;
    check_output($sformatf("an k=%0d", k), {4'h0, bus.an}, {4'h0, exp_an});
    check_output($sformatf("seg k=%0d", k), bus.seg, exp_seg[d]);
    check_output($sformatf("frame_tick k=%0d", k), {7'h0, bus.frame_tick}, {7'h0, (k == FRAME_CYC - 1)});
  endtask

  task automatic check_range(input int first, input int last);
    for (int k = first; k <= last; k++) step_check(k);
  endtask

  task automatic wait_frame();
    for (int i = 0; i < FRAME_CYC + 8; i++) begin
      @(negedge clk);
      if (bus.frame_tick === 1'b1) return;
    end
    total++;
    bad++;
    $display("[TB] FAIL frame_wait: got no frame_tick expected one within %0d cycles", FRAME_CYC + 8);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, " an"}, {4'h0, bus.an}, 8'h0F);
    check_output({tag, " seg"}, bus.seg, 8'hFF);
    check_output({tag, " frame_tick"}, {7'h0, bus.frame_tick}, 8'h00);
  endtask

  initial begin
    vec_t v1234;
    vecs[0] = '{n0:4'd4, n1:4'd3, n2:4'd2, n3:4'd1, can:4'b1111, dp:4'b0000,
                s0:8'h99, s1:8'hB0, s2:8'hA4, s3:8'hF9};
    vecs[1] = '{n0:4'd7, n1:4'd0, n2:4'd0, n3:4'd0, can:4'b0001, dp:4'b0000,
                s0:8'hF8, s1:8'hC0, s2:8'hC0, s3:8'hC0};
    vecs[2] = '{n0:4'd7, n1:4'd0, n2:4'd0, n3:4'd0, can:4'b0001, dp:4'b0001,
                s0:8'h78, s1:8'hC0, s2:8'hC0, s3:8'hC0};
    vecs[3] = '{n0:4'd6, n1:4'd8, n2:4'd12, n3:4'd9, can:4'b1111, dp:4'b1010,
                s0:8'h82, s1:8'h00, s2:8'hBF, s3:8'h10};
    vecs[4] = '{n0:4'd7, n1:4'd5, n2:4'd1, n3:4'd0, can:4'b0111, dp:4'b0100,
                s0:8'hF8, s1:8'h92, s2:8'h79, s3:8'hC0};
    v1234 = vecs[0];

    rst_n     = 1'b0;
    bus.num0  = '0;
    bus.num1  = '0;
    bus.num2  = '0;
    bus.num3  = '0;
    bus.can_num = 4'b0001;
    bus.dp_mask = '0;
    bus.blink = 1'b0;
    exp_dark  = 1'b0;

    // Reset and default display.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_reset_outputs("reset");
    end
    rst_n = 1'b1;
    set_reset_expect();
    check_range(0, FRAME_CYC - 1);

    // Table of display values, each captured at the next frame boundary.
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(vecs[i]);
      wait_frame();
      set_expect(vecs[i]);
      check_range(0, FRAME_CYC - 1);
    end

    // Snapshot coherence: mid-frame change of num0 waits for the boundary.
    apply_stimulus(v1234);
    wait_frame();
    set_expect(v1234);
    check_range(0, FRAME_CYC - 1);
    check_range(0, 3);
    bus.num0 = 4'd5;
    check_range(4, FRAME_CYC - 1);
    exp_seg[0] = 8'h92;
    check_range(0, FRAME_CYC - 1);

    // Blink: two frames lit, two dark, repeating; then drop and re-raise.
    bus.blink = 1'b1;
    for (int f = 0; f < 7; f++) begin
      exp_dark = (f == 2 || f == 3 || f == 6);
      check_range(0, FRAME_CYC - 1);
    end
    bus.blink = 1'b0;
    exp_dark  = 1'b0;
    check_range(0, FRAME_CYC - 1);
    bus.blink = 1'b1;
    check_range(0, FRAME_CYC - 1);
    bus.blink = 1'b0;
    check_range(0, FRAME_CYC - 1);

    // Dash digit and reset asserted inside the digit-2 slot.
    apply_stimulus(vecs[3]);
    wait_frame();
    set_expect(vecs[3]);
    check_range(0, 2 * SCAN_DIV + 3);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    set_reset_expect();
    check_range(0, FRAME_CYC - 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan.md
Name: seg_scan

Overview:
- Time-multiplexed 7-segment driver for the 4-digit score/base display.
- Sits directly downstream of the binary-to-BCD stage and consumes its num0..num3 digits and can_num digit-enable mask.
- Scans one digit at a time and blanks leading digits whose can_num bit is clear.
- Snapshots inputs once per frame so a display never mixes digits from two values; adds anti-ghosting blanking, a per-digit decimal point and a blink mode.

Parameters:
SCAN_DIV, 100000, clk cycles per digit slot (1 kHz/digit at 100 MHz); legal range >= BLANK_CYC+2.
BLANK_CYC, 200, cycles at the start of each slot with all anodes off (anti-ghosting); legal range >= 0.
BLINK_FRAMES, 125, frames per blink half-period; legal range >= 1.
CNT_W, 17, prescaler width; must satisfy 2^CNT_W >= SCAN_DIV.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active low
num0..num3  in  4 each  BCD digits, num0 least significant; values 10..15 are legal and shown as '-'
can_num  in  4  digit enable; bit i=0 blanks digit i
dp_mask  in  4  bit i=1 lights decimal point of digit i
blink  in  1  1 = flash whole display
an  out  4  anodes, active low, an[i] = digit i
seg  out  8  active-low segments {dp,g,f,e,d,c,b,a}
frame_tick  out  1  one-cycle pulse when a new snapshot is taken

Behaviour:
- Single clock domain. Reset is synchronous and active-low: the block samples rst_n only on the rising edge of clk.
- Reset values: an=4'b1111, seg=8'hFF, frame_tick=0, cnt=0, idx=0, frame_cnt=0, phase=0, shadow digits=0, shadow_dp=0, shadow_can=4'b0001.
- Prescaler: cnt increments every cycle. tick = (cnt==SCAN_DIV-1). On tick, cnt<=0.
- Digit index: on tick, idx<=idx+1, wrapping from 3 to 0.
- Snapshot: on a tick with idx==3, load shadow num/can/dp from the inputs and set frame_tick<=1. At all other times frame_tick<=0.
  - Input changes outside that edge have no effect until the next frame boundary.
  - The first snapshot after reset occurs at cycle 4*SCAN_DIV-1.
- Blink:
  - While blink=0, frame_cnt<=0 and phase<=0 on every cycle.
  - While blink=1, each snapshot edge increments frame_cnt. When frame_cnt==BLINK_FRAMES-1, frame_cnt wraps to 0 and phase toggles.
- Output registers are updated every cycle from the current (pre-edge) cnt/idx/shadow/phase, so outputs lag state by 1 cycle:
  - an <= 4'b1111 if (cnt<BLANK_CYC) or !shadow_can[idx] or (blink && phase); otherwise an is all ones except bit idx=0.
  - seg <= {~shadow_dp[idx], dec(shadow_num[idx])}. seg is driven even when an is blank.
- dec (active-low g..a):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - 10..15 = 3F ('-').
- can_num[0] is not forced high here; the upstream stage guarantees it.
- Reset mid-operation: the cycle after the rst_n=0 edge shows all reset values, and the scan restarts at digit 0.
- No handshake. Inputs are treated as quasi-static level signals and need no synchronisation (same clock).

Decomposition:
- seg_pkg holds:
  - the segment code constants SEG_0..SEG_9 and SEG_DASH;
  - SEG_OFF=8'hFF and AN_OFF=4'hF;
  - NUM_DIGITS=4.
- One combinational sub-module, seg_decode (4-bit digit -> 7-bit active-low segments), instantiated once on the muxed shadow digit.

Test Plan:
All scenarios use SCAN_DIV=8, BLANK_CYC=2, BLINK_FRAMES=2.
- Reset and default display: rst_n low 3 cycles, all inputs 0, can_num=0001 -> an=1111 and seg=FF during reset. After release, digit 0 shows seg=C0 with an=1110 for cnt 2..7 of its slot, and an[3:1] stay 1.
- Value 1234: num3..num0=1,2,3,4, can=1111, dp=0 -> after the first frame_tick, one frame shows (an,seg) = (1110,99), (1101,B0), (1011,A4), (0111,F9), each low for 6 of 8 cycles.
- Leading-zero blank: num=0,0,0,7, can=0001 -> only an[0] ever goes low, with seg=F8. Then set dp_mask=0001 -> seg=78 after the next frame boundary.
- Snapshot coherence: change num0 from 4 to 5 mid-frame -> seg stays 99 in the digit-0 slot until the frame_tick pulse, then shows 92. frame_tick is high exactly 1 cycle every 32.
- Blink: blink=1 from a frame boundary -> frames 0-1 scan normally, frames 2-3 have an=1111 throughout, frames 4-5 scan normally. Drop blink -> normal scan the next cycle with phase=0.
- Dash and mid-scan reset: num2=12 -> digit 2 shows seg=BF. Assert rst_n=0 during the digit-2 slot -> next cycle an=1111, seg=FF. After release, the scan resumes at digit 0 showing C0.
